// File: rtl/soc_event_pkg.sv
// rtl/soc_event_pkg.sv - shared defaults and event ID type for the SoC event queue
package soc_event_pkg;

   localparam int EVENT_ID_WIDTH_DEF = 8;
   localparam int FIFO_DEPTH_DEF     = 4;

   typedef logic [EVENT_ID_WIDTH_DEF-1:0] event_id_t;

endpackage

// File: rtl/soc_event_queue_if.sv
// rtl/soc_event_queue_if.sv - event FIFO handshake and overrun report towards the FC
interface soc_event_queue_if import soc_event_pkg::*; #(
   parameter int EVENT_ID_WIDTH = EVENT_ID_WIDTH_DEF
);

   logic                      event_fifo_valid_o;
   logic                      event_fifo_fulln_i;
   logic [EVENT_ID_WIDTH-1:0] event_fifo_data_o;
   logic                      err_o;
   logic [EVENT_ID_WIDTH-1:0] err_id_o;

   modport master (
      output event_fifo_valid_o,
      output event_fifo_data_o,
      output err_o,
      output err_id_o,
      input  event_fifo_fulln_i
   );

   modport slave (
      input  event_fifo_valid_o,
      input  event_fifo_data_o,
      input  err_o,
      input  err_id_o,
      output event_fifo_fulln_i
   );

endinterface

// File: rtl/soc_event_rr_arb.sv
// rtl/soc_event_rr_arb.sv - round-robin arbiter, search starts at rr_ptr and wraps at N-1
module soc_event_rr_arb #(
   parameter int N     = 32,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [N-1:0]     req,
   input  logic             en,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] gnt_idx
);

   logic [IDX_W-1:0] rr_ptr;

   // Walk from the farthest candidate to the nearest so the nearest request wins.
   always_comb begin
      int idx;
      idx     = 0;
      gnt     = '0;
      gnt_idx = '0;
      if (en) begin
         for (int off = N - 1; off >= 0; off--) begin
            idx = int'(rr_ptr) + off;
            if (idx >= N) idx = idx - N;
            if (req[idx]) begin
               gnt      = '0;
               gnt[idx] = 1'b1;
               gnt_idx  = IDX_W'(idx);
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_ptr <= '0;
      end else if (|gnt) begin
         rr_ptr <= (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + 1'b1;
      end
   end

endmodule

// File: rtl/soc_event_queue.sv
// rtl/soc_event_queue.sv - pending flags, overrun report and output FIFO for SoC event pulses
module soc_event_queue import soc_event_pkg::*; #(
   parameter int NB_EVENTS      = 32,
   parameter int EVENT_ID_WIDTH = EVENT_ID_WIDTH_DEF,
   parameter int FIFO_DEPTH     = FIFO_DEPTH_DEF
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [NB_EVENTS-1:0] event_i,
   soc_event_queue_if.master    fifo_if
);

   localparam int IDX_W = (NB_EVENTS > 1) ? $clog2(NB_EVENTS) : 1;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [NB_EVENTS-1:0]      pend;
   logic [NB_EVENTS-1:0]      gnt;
   logic [NB_EVENTS-1:0]      ovr;
   logic [IDX_W-1:0]          gnt_idx;
   logic [EVENT_ID_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]          wr_ptr;
   logic [PTR_W-1:0]          rd_ptr;
   logic [CNT_W-1:0]          count;
   logic                      empty;
   logic                      full;
   logic                      push;
   logic                      pop;
   logic                      push_ok;
   logic [EVENT_ID_WIDTH-1:0] push_id;
   logic [EVENT_ID_WIDTH-1:0] ovr_id;
   logic                      err_q;
   logic [EVENT_ID_WIDTH-1:0] err_id_q;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(FIFO_DEPTH));
   assign pop     = !empty && fifo_if.event_fifo_fulln_i;
   assign push_ok = !full || pop;
   assign push    = |gnt;

   soc_event_rr_arb #(
      .N     (NB_EVENTS),
      .IDX_W (IDX_W)
   ) u_arb (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .req     (pend),
      .en      (push_ok),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   // A pulse on a source that is being granted this cycle is not an overrun.
   assign ovr = event_i & pend & ~gnt;

   always_comb begin
      push_id              = '0;
      push_id[IDX_W-1:0]   = gnt_idx;
      ovr_id               = '0;
      for (int i = NB_EVENTS - 1; i >= 0; i--) begin
         if (ovr[i]) ovr_id = EVENT_ID_WIDTH'(i);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pend     <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         err_q    <= 1'b0;
         err_id_q <= '0;
      end else begin
         pend     <= (pend & ~gnt) | event_i;
         err_q    <= |ovr;
         err_id_q <= ovr_id;
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr] <= push_id;
   end

   // Storage is not reset, so the head is masked while empty to keep stale IDs off the bus.
   assign fifo_if.event_fifo_valid_o = !empty;
   assign fifo_if.event_fifo_data_o  = empty ? '0 : mem[rd_ptr];
   assign fifo_if.err_o              = err_q;
   assign fifo_if.err_id_o           = err_id_q;

endmodule

// File: tb/tb_soc_event_queue.sv
// tb/tb_soc_event_queue.sv - self-checking bench for soc_event_queue
module tb_soc_event_queue;
   import soc_event_pkg::*;

   localparam int N     = 32;
   localparam int DEPTH = 4;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] ev    = '0;

   always #5 clk = ~clk;

   soc_event_queue_if #(.EVENT_ID_WIDTH(8)) fifo_if ();

   soc_event_queue #(
      .NB_EVENTS      (N),
      .EVENT_ID_WIDTH (8),
      .FIFO_DEPTH     (DEPTH)
   ) dut (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .event_i (ev),
      .fifo_if (fifo_if)
   );

   int n_assert = 0;
   int n_fail   = 0;

   bit m_pend [N];
   int m_rr;
   int m_q [$];
   bit m_err;
   int m_err_id;

   int dut_log [$];
   int valid_cyc [$];
   int err_cnt;
   int last_err_id;
   int cyc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_log(input string tag, input int exp[$]);
      chk({tag, "_len"}, 32'(dut_log.size()), 32'(exp.size()));
      for (int i = 0; i < exp.size() && i < dut_log.size(); i++)
         chk(tag, 32'(dut_log[i]), 32'(exp[i]));
   endtask

   function automatic logic [N-1:0] bitm(input int i);
      logic [N-1:0] m;
      m    = '0;
      m[i] = 1'b1;
      return m;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
      m_rr = 0;
      m_q.delete();
      m_err = 1'b0;
      m_err_id = 0;
   endtask

   task automatic clear_logs();
      dut_log.delete();
      valid_cyc.delete();
      err_cnt = 0;
      last_err_id = -1;
      cyc = 0;
   endtask

   // One clock: check current outputs against the model, then advance model and DUT.
   task automatic cycle(input logic [N-1:0] e, input logic fl);
      int g;
      int lost;
      int idx;
      bit pop;
      bit ok;
      ev = e;
      fifo_if.event_fifo_fulln_i = fl;
      chk("valid", 32'(fifo_if.event_fifo_valid_o), 32'(m_q.size() != 0));
      if (m_q.size() != 0) chk("data", 32'(fifo_if.event_fifo_data_o), 32'(m_q[0]));
      chk("err", 32'(fifo_if.err_o), 32'(m_err));
      if (m_err) chk("err_id", 32'(fifo_if.err_id_o), 32'(m_err_id));
      if (fifo_if.event_fifo_valid_o === 1'b1) valid_cyc.push_back(cyc);
      if (fifo_if.event_fifo_valid_o === 1'b1 && fl) dut_log.push_back(int'(fifo_if.event_fifo_data_o));
      if (fifo_if.err_o === 1'b1) begin
         err_cnt++;
         last_err_id = int'(fifo_if.err_id_o);
      end
      pop = (m_q.size() != 0) && fl;
      ok  = (m_q.size() < DEPTH) || pop;
      g = -1;
      if (ok) begin
         for (int off = 0; off < N; off++) begin
            idx = (m_rr + off) % N;
            if (g < 0 && m_pend[idx]) g = idx;
         end
      end
      lost = -1;
      for (int i = 0; i < N; i++)
         if (e[i] && m_pend[i] && i != g && lost < 0) lost = i;
      for (int i = 0; i < N; i++)
         m_pend[i] = (i == g) ? e[i] : (m_pend[i] | e[i]);
      if (pop) void'(m_q.pop_front());
      if (g >= 0) begin
         m_q.push_back(g);
         m_rr = (g + 1) % N;
      end
      m_err    = (lost >= 0);
      m_err_id = (lost >= 0) ? lost : 0;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n, input logic fl);
      repeat (n) cycle('0, fl);
   endtask

   task automatic reset_dut();
      ev = '0;
      rst_n = 1'b0;
      #1;
      chk("rst_valid", 32'(fifo_if.event_fifo_valid_o), 32'd0);
      chk("rst_err", 32'(fifo_if.err_o), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      model_clear();
      @(posedge clk);
      #1;
      clear_logs();
   endtask

   initial begin
      int e [$];
      fifo_if.event_fifo_fulln_i = 1'b1;
      model_clear();
      clear_logs();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_valid", 32'(fifo_if.event_fifo_valid_o), 32'd0);
      chk("reset_data", 32'(fifo_if.event_fifo_data_o), 32'd0);
      chk("reset_err", 32'(fifo_if.err_o), 32'd0);
      chk("reset_err_id", 32'(fifo_if.err_id_o), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Single event: visible two cycles after the pulse, for one cycle.
      clear_logs();
      cycle(bitm(5), 1'b1);
      idle(5, 1'b1);
      chk("single_nvalid", 32'(valid_cyc.size()), 32'd1);
      if (valid_cyc.size() > 0) chk("single_cycle", 32'(valid_cyc[0]), 32'd2);
      e = '{5};
      chk_log("single_id", e);
      chk("single_err", 32'(err_cnt), 32'd0);

      // Simultaneous events in index order on consecutive cycles.
      reset_dut();
      cycle(bitm(3) | bitm(7) | bitm(12), 1'b1);
      idle(6, 1'b1);
      e = '{3, 7, 12};
      chk_log("simul_id", e);
      chk("simul_nvalid", 32'(valid_cyc.size()), 32'd3);
      if (valid_cyc.size() == 3) chk("simul_start", 32'(valid_cyc[0]), 32'd2);
      if (valid_cyc.size() == 3) chk("simul_end", 32'(valid_cyc[2]), 32'd4);

      // Backpressure: FIFO holds 0..3, 4 and 5 wait pending.
      reset_dut();
      cycle(N'(32'h3F), 1'b0);
      idle(6, 1'b0);
      chk("bp_valid", 32'(fifo_if.event_fifo_valid_o), 32'd1);
      chk("bp_head", 32'(fifo_if.event_fifo_data_o), 32'd0);
      idle(8, 1'b1);
      e = '{0, 1, 2, 3, 4, 5};
      chk_log("bp_order", e);

      // Overrun on source 9 while the FIFO is full.
      reset_dut();
      cycle(N'(32'hF), 1'b0);
      idle(5, 1'b0);
      cycle(bitm(9), 1'b0);
      idle(1, 1'b0);
      cycle(bitm(9), 1'b0);
      idle(3, 1'b0);
      idle(10, 1'b1);
      chk("ovr_pulses", 32'(err_cnt), 32'd1);
      chk("ovr_id", 32'(last_err_id), 32'd9);
      e = '{0, 1, 2, 3, 9};
      chk_log("ovr_deliv", e);

      // Fairness between two sources pulsing every other cycle.
      reset_dut();
      repeat (6) begin
         cycle(bitm(1) | bitm(2), 1'b1);
         cycle('0, 1'b1);
      end
      idle(4, 1'b1);
      e = '{1, 2, 1, 2, 1, 2, 1, 2, 1, 2, 1, 2};
      chk_log("rr_alt", e);
      chk("rr_err", 32'(err_cnt), 32'd0);

      // Pointer wrap from the top index back to 0.
      reset_dut();
      cycle(bitm(31), 1'b1);
      cycle(bitm(0), 1'b1);
      idle(4, 1'b1);
      e = '{31, 0};
      chk_log("wrap", e);

      // Reset with IDs queued and a source still pending.
      reset_dut();
      cycle(bitm(10) | bitm(11) | bitm(12) | bitm(13), 1'b0);
      idle(3, 1'b0);
      chk("pre_rst_valid", 32'(fifo_if.event_fifo_valid_o), 32'd1);
      reset_dut();
      idle(6, 1'b1);
      chk("post_rst_quiet", 32'(valid_cyc.size()), 32'd0);
      cycle(bitm(20), 1'b1);
      idle(4, 1'b1);
      e = '{20};
      chk_log("post_rst_new", e);

      // Randomized traffic and backpressure against the reference model.
      reset_dut();
      for (int k = 0; k < 600; k++)
         cycle(N'($urandom() & $urandom() & $urandom()), $urandom_range(0, 3) != 0);
      idle(40, 1'b1);
      chk("rand_drained", 32'(fifo_if.event_fifo_valid_o), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
